fb_rect_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_addr_walker.sv | 80 ++++++++
 rtl/fb_rect_writer.sv | 121 ++++++++++++
 tb/tb_fb_rect_writer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants for the write-side engine: geometry, op codes,
// colour codes and the clipped-rectangle record handed to the address walker.
package fb_pkg;

  localparam int PX_WIDTH  = 160;  // logical pixels per row (4x4 screen pixels each)
  localparam int PX_HEIGHT = 120;  // logical rows
  localparam int ADDR_W    = 16;   // PX_WIDTH*PX_HEIGHT = 19200 fits in 2^16

  localparam logic OP_FILL  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam logic [2:0] COL_BG     = 3'd0;
  localparam logic [2:0] COL_RED    = 3'd1;
  localparam logic [2:0] COL_ORANGE = 3'd2;
  localparam logic [2:0] COL_YELLOW = 3'd3;
  localparam logic [2:0] COL_PLAYER = 3'd6;

  // Clipped rectangle: start is inclusive, end is exclusive.
  typedef struct packed {
    logic [7:0] x0;
    logic [8:0] x1;
    logic [6:0] y0;
    logic [7:0] y1;
  } rect_t;

  // Address of column 0 in a given row. Constant multiply, used only when a
  // command is loaded; the walker advances rows by addition.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [6:0] row);
    return ADDR_W'(row) * ADDR_W'(PX_WIDTH);
  endfunction

endpackage

// File: rtl/fb_addr_walker.sv
// Raster-order address generator for one clipped rectangle. Holds the column,
// row and running row base address; a step moves one pixel right, wrapping to
// the next row at the right edge.
module fb_addr_walker
  import fb_pkg::*;
(
  input  logic              dclk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        x_start,
  input  logic [8:0]        x_end,
  input  logic [6:0]        y_start,
  input  logic [7:0]        y_end,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [7:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [7:0]        x_start_q, x_start_d;
  logic [8:0]        x_end_q, x_end_d;
  logic [7:0]        y_end_q, y_end_d;
  logic              row_end;

  assign row_end = ({1'b0, col_q} == (x_end_q - 9'd1));
  assign last    = row_end && ({1'b0, row_q} == (y_end_q - 8'd1));
  assign addr    = row_base_q + ADDR_W'(col_q);

  // Next position: reload on a new command, otherwise advance on step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    if (load) begin
      col_d      = x_start;
      row_d      = y_start;
      row_base_d = row_base_of(y_start);
      x_start_d  = x_start;
      x_end_d    = x_end;
      y_end_d    = y_end;
    end else if (step) begin
      if (row_end) begin
        col_d      = x_start_q;
        row_d      = row_q + 7'd1;
        row_base_d = row_base_q + ADDR_W'(PX_WIDTH);
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Position and bound registers.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Framebuffer write engine: accepts fill-rectangle / clear-screen commands on
// a valid/ready handshake, clips them to the screen and emits one write per
// dclk in raster order. Optional macro FB_VBLANK_GATE_EN adds a vblank input
// that stalls writing outside vertical blanking.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              dclk,
  input  logic              clr,
`ifdef FB_VBLANK_GATE_EN
  input  logic              vblank,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [2:0]        cmd_color,
  output logic [ADDR_W-1:0] wmemaddr,
  output logic [2:0]        wmemdata,
  output logic              wmemen,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        color_q, color_d;
  logic [8:0]        x_sum;
  logic [7:0]        y_sum;
  rect_t             clip;
  logic              clip_empty;
  logic              accept;
  logic              go;
  logic              walk_step;
  logic              walk_last;
  logic [ADDR_W-1:0] walk_addr;

`ifdef FB_VBLANK_GATE_EN
  assign go = vblank;
`else
  assign go = 1'b1;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign walk_step = (state_q == ST_WRITE) && go;

  assign wmemen   = walk_step;
  assign wmemaddr = (state_q == ST_WRITE) ? walk_addr : '0;
  assign wmemdata = (state_q == ST_WRITE) ? color_q : '0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  // Clip the incoming command to the screen; the sums are one bit wider than
  // the operands so an overhanging rectangle cannot wrap.
  always_comb begin
    x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};
    clip  = '0;
    if (cmd_op == OP_CLEAR) begin
      clip.x1 = 9'(PX_WIDTH);
      clip.y1 = 8'(PX_HEIGHT);
    end else begin
      clip.x0 = cmd_x;
      clip.y0 = cmd_y;
      clip.x1 = (x_sum > 9'(PX_WIDTH))  ? 9'(PX_WIDTH)  : x_sum;
      clip.y1 = (y_sum > 8'(PX_HEIGHT)) ? 8'(PX_HEIGHT) : y_sum;
    end
    clip_empty = ({1'b0, clip.x0} >= clip.x1) || ({1'b0, clip.y0} >= clip.y1);
  end

  // Command FSM: IDLE -> WRITE (or straight to DONE when nothing to draw) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          color_d = cmd_color;
          state_d = clip_empty ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (walk_step && walk_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched colour.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
    end
  end

  fb_addr_walker u_walker (
    .dclk    (dclk),
    .clr     (clr),
    .load    (accept),
    .step    (walk_step),
    .x_start (clip.x0),
    .x_end   (clip.x1),
    .y_start (clip.y0),
    .y_end   (clip.y1),
    .addr    (walk_addr),
    .last    (walk_last)
  );

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: reset values, clipped fills, empty fills,
// full clear, mid-clear reset and (with FB_VBLANK_GATE_EN) a vblank stall.
module tb_fb_rect_writer;
  import fb_pkg::*;

  logic              dclk = 1'b0;
  logic              clr = 1'b0;
`ifdef FB_VBLANK_GATE_EN
  logic              vblank = 1'b1;
`endif
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [7:0]        cmd_x = '0;
  logic [6:0]        cmd_y = '0;
  logic [7:0]        cmd_w = '0;
  logic [6:0]        cmd_h = '0;
  logic [2:0]        cmd_color = '0;
  logic [ADDR_W-1:0] wmemaddr;
  logic [2:0]        wmemdata;
  logic              wmemen;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  always #5 dclk = ~dclk;

  fb_rect_writer dut (
    .dclk      (dclk),
    .clr       (clr),
`ifdef FB_VBLANK_GATE_EN
    .vblank    (vblank),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wmemaddr  (wmemaddr),
    .wmemdata  (wmemdata),
    .wmemen    (wmemen),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  // Present a command in IDLE and let the next edge accept it.
  task automatic issue(input string tag, input logic op, input int x, input int y,
                       input int w, input int h, input int color);
    check({tag, "_ready"}, 32'(cmd_ready), 1);
    cmd_op    = op;
    cmd_x     = 8'(x);
    cmd_y     = 7'(y);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = 3'(color);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input int addr, input int data);
    check({tag, "_en"},   32'(wmemen), 1);
    check({tag, "_addr"}, 32'(wmemaddr), 32'(addr));
    check({tag, "_data"}, 32'(wmemdata), 32'(data));
    check({tag, "_busy"}, 32'(busy), 1);
    tick();
  endtask

  // One-cycle done pulse, then back to IDLE with cmd_ready high.
  task automatic expect_done(input string tag);
    check({tag, "_done"},    32'(done), 1);
    check({tag, "_en0"},     32'(wmemen), 0);
    check({tag, "_rdy0"},    32'(cmd_ready), 0);
    check({tag, "_busyD"},   32'(busy), 1);
    tick();
    check({tag, "_done0"},   32'(done), 0);
    check({tag, "_rdy1"},    32'(cmd_ready), 1);
    check({tag, "_idle"},    32'(busy), 0);
  endtask

  initial begin
    int n;
    int errs;
    int found;
    logic got_done;

    // Reset
    #1 clr = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_en",    32'(wmemen), 0);
    check("rst_addr",  32'(wmemaddr), 0);
    check("rst_data",  32'(wmemdata), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    clr = 1'b0;
    tick();

    // Fill 2x2 at (2,3): 3*160+2 = 482, 483; 4*160+2 = 642, 643
    issue("f1", OP_FILL, 2, 3, 2, 2, COL_RED);
    expect_write("f1w0", 482, 1);
    expect_write("f1w1", 483, 1);
    expect_write("f1w2", 642, 1);
    expect_write("f1w3", 643, 1);
    expect_done("f1");

    // Bottom-right overhang clips to (158..159, 119): 119*160+158 = 19198
    issue("f2", OP_FILL, 158, 119, 5, 4, COL_YELLOW);
    expect_write("f2w0", 19198, 3);
    expect_write("f2w1", 19199, 3);
    expect_done("f2");

    // Zero width: no writes, done the cycle after acceptance
    issue("f3", OP_FILL, 10, 10, 0, 5, COL_RED);
    expect_done("f3");

    // Start column off screen: empty after clipping
    issue("f4", OP_FILL, 200, 10, 5, 5, COL_RED);
    expect_done("f4");

    // Zero height
    issue("f5", OP_FILL, 10, 10, 3, 0, COL_RED);
    expect_done("f5");

    // Full clear: 19200 contiguous writes, ignoring cmd_x/y/w/h
    issue("clr", OP_CLEAR, 50, 50, 1, 1, COL_BG);
    n = 0;
    errs = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (!(wmemen === 1'b1 && busy === 1'b1 && wmemaddr === ADDR_W'(n) && wmemdata === 3'd0))
          errs++;
        n++;
        tick();
      end
    end
    check("clr_done_seen", 32'(got_done), 1);
    check("clr_count", 32'(n), 19200);
    check("clr_seq_errs", 32'(errs), 0);
    expect_done("clr");

    // Reset in the middle of a clear
    issue("abort", OP_CLEAR, 0, 0, 0, 0, COL_ORANGE);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      if (wmemen === 1'b1 && wmemaddr === ADDR_W'(500)) found = 1;
      else tick();
    end
    check("abort_reach500", 32'(found), 1);
    #2 clr = 1'b1;
    #1;
    check("abort_en",    32'(wmemen), 0);
    check("abort_ready", 32'(cmd_ready), 1);
    check("abort_busy",  32'(busy), 0);
    check("abort_addr",  32'(wmemaddr), 0);
    tick();
    clr = 1'b0;
    tick();

    // Fill after reset executes normally: (0,0) 1x1 then (159,0) 1x2
    issue("f6", OP_FILL, 0, 0, 1, 1, COL_PLAYER);
    expect_write("f6w0", 0, 6);
    expect_done("f6");
    issue("f7", OP_FILL, 159, 0, 1, 2, COL_ORANGE);
    expect_write("f7w0", 159, 2);
    expect_write("f7w1", 319, 2);
    expect_done("f7");

`ifdef FB_VBLANK_GATE_EN
    // Vblank stall mid-fill: 3x2 at (10,5) -> 810,811,812,970,971,972
    vblank = 1'b1;
    issue("vb", OP_FILL, 10, 5, 3, 2, COL_YELLOW);
    expect_write("vbw0", 810, 3);
    expect_write("vbw1", 811, 3);
    vblank = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("vb_stall_en",   32'(wmemen), 0);
      check("vb_stall_addr", 32'(wmemaddr), 812);
      check("vb_stall_busy", 32'(busy), 1);
      tick();
    end
    vblank = 1'b1;
    #1;
    expect_write("vbw2", 812, 3);
    expect_write("vbw3", 970, 3);
    expect_write("vbw4", 971, 3);
    expect_write("vbw5", 972, 3);
    expect_done("vb");

    // Acceptance is not gated by vblank
    vblank = 1'b0;
    issue("vb2", OP_FILL, 0, 1, 1, 1, COL_RED);
    check("vb2_busy", 32'(busy), 1);
    check("vb2_en",   32'(wmemen), 0);
    vblank = 1'b1;
    #1;
    expect_write("vb2w0", 160, 1);
    expect_done("vb2");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
